// File: rtl/sdram_sort_pkg.sv
// sdram_sort_pkg: FSM state codes and sort-order constants shared by the sort engine files
package sdram_sort_pkg;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic ORDER_ASC  = 1'b0;
  localparam logic ORDER_DESC = 1'b1;
endpackage

// File: rtl/sort_insert_array.sv
// sort_insert_array: stable insertion-sort register array (clear, ins_valid/ins_data/descending in; rd_idx in, rd_data out)
module sort_insert_array
  import sdram_sort_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int MAX_LEN = 32
) (
  input  logic                       clk,
  input  logic                       clear,
  input  logic                       ins_valid,
  input  logic [DATA_W-1:0]          ins_data,
  input  logic                       descending,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx,
  output logic [DATA_W-1:0]          rd_data
);
  logic [DATA_W-1:0] data [MAX_LEN];
  logic [DATA_W-1:0] prev_data [MAX_LEN];
  logic [MAX_LEN-1:0] valid, take, shift;
  always_comb begin
    prev_data[0] = ins_data;
    for (int i = 1; i < MAX_LEN; i++) prev_data[i] = data[i-1];
    for (int i = 0; i < MAX_LEN; i++)
      take[i] = !valid[i] || (descending == ORDER_DESC ? ins_data > data[i] : ins_data < data[i]);
  end
  // take is monotonic over a sorted array, so an entry whose predecessor also takes shifts down
  assign shift = {take[MAX_LEN-2:0], 1'b0};
  assign rd_data = data[rd_idx];
  always_ff @(posedge clk) begin
    if (clear) valid <= '0;
    else if (ins_valid) valid <= valid | {valid[MAX_LEN-2:0], 1'b1};
    if (ins_valid)
      for (int i = 0; i < MAX_LEN; i++)
        if (take[i]) data[i] <= shift[i] ? prev_data[i] : ins_data;
  end
endmodule

// File: rtl/sdram_sort_engine.sv
// sdram_sort_engine: Avalon-MM master reading length words at src_base, insertion-sorting them, writing them to dst_base (start/length/bases in; busy/done/error/min/max out)
module sdram_sort_engine
  import sdram_sort_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 32,
  parameter int MAX_LEN     = 32,
  parameter int LEN_W       = 6,
  parameter int ADDR_STRIDE = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                waitrequest,
  input  logic                readdatavalid,
  input  logic [DATA_W-1:0]   readdata,
  output logic                read_n,
  output logic                write_n,
  output logic                chipselect,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                start,
  input  logic                descending,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dst_base,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   min_val,
  output logic [DATA_W-1:0]   max_val
);
  localparam int IDX_W = $clog2(MAX_LEN);
  logic [2:0] state;
  logic desc_r, run_ok, acc;
  logic [ADDR_W-1:0] dst_r;
  logic [LEN_W-1:0] len_r, rd_issued, rx_cnt, wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0] sorted;
  assign run_ok = length != '0 && length <= LEN_W'(MAX_LEN);
  assign acc = readdatavalid && (state == READ || state == DRAIN);
  // the read port looks one entry ahead so writedata is ready when the current beat is accepted
  assign rd_idx = state == WRITE ? IDX_W'(wr_idx + 1'b1) : '0;
  assign chipselect = !read_n || !write_n;
  assign byteenable = '1;
  assign busy = state == READ || state == DRAIN || state == WRITE;
  assign done = state == DONE;
  sort_insert_array #(.DATA_W(DATA_W), .MAX_LEN(MAX_LEN)) u_sort (
    .clk(clk),
    .clear(!reset_n || (state == IDLE && start && run_ok)),
    .ins_valid(acc),
    .ins_data(readdata),
    .descending(desc_r),
    .rd_idx(rd_idx),
    .rd_data(sorted)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      read_n <= 1'b1;
      write_n <= 1'b1;
      address <= '0;
      writedata <= '0;
      error <= 1'b0;
      min_val <= '1;
      max_val <= '0;
      desc_r <= 1'b0;
      dst_r <= '0;
      len_r <= '0;
      rd_issued <= '0;
      rx_cnt <= '0;
      wr_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          desc_r <= descending;
          dst_r <= dst_base;
          len_r <= length;
          rd_issued <= '0;
          rx_cnt <= '0;
          wr_idx <= '0;
          min_val <= '1;
          max_val <= '0;
          if (run_ok) begin
            state <= READ;
            read_n <= 1'b0;
            address <= src_base;
          end else begin
            state <= DONE;
            error <= length != '0;
          end
        end
        READ: if (!waitrequest) begin
          rd_issued <= rd_issued + 1'b1;
          if (rd_issued == len_r - 1'b1) begin
            read_n <= 1'b1;
            state <= DRAIN;
          end else address <= address + ADDR_W'(ADDR_STRIDE);
        end
        DRAIN: if (rx_cnt == len_r) begin
          state <= WRITE;
          write_n <= 1'b0;
          address <= dst_r;
          writedata <= sorted;
        end
        WRITE: if (!waitrequest) begin
          if (wr_idx == len_r - 1'b1) begin
            write_n <= 1'b1;
            state <= DONE;
          end else begin
            wr_idx <= wr_idx + 1'b1;
            address <= address + ADDR_W'(ADDR_STRIDE);
            writedata <= sorted;
          end
        end
        DONE: if (!start) begin
          state <= IDLE;
          error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (acc) begin
        rx_cnt <= rx_cnt + 1'b1;
        if (readdata < min_val) min_val <= readdata;
        if (readdata > max_val) max_val <= readdata;
      end
    end
  end
endmodule

// File: tb/tb_sdram_sort_engine.sv
// tb_sdram_sort_engine: directed bench with an SDRAM slave model and a sorted-list reference for sdram_sort_engine
module tb_sdram_sort_engine;
  logic clk = 1'b0, reset_n = 1'b0, waitrequest = 1'b0, readdatavalid = 1'b0;
  logic [15:0] readdata = '0;
  logic read_n, write_n, chipselect;
  logic [31:0] address;
  logic [1:0] byteenable;
  logic [15:0] writedata, min_val, max_val;
  logic start = 1'b0, descending = 1'b0;
  logic [31:0] src_base = '0, dst_base = '0;
  logic [5:0] length = '0;
  logic busy, done, error;
  int total = 0, bad = 0;
  logic [15:0] mem [logic [31:0]];
  logic [15:0] din[$], exp_q[$], pd[$];
  int pt[$];
  logic [31:0] src_r, dst_r, rd_addrs[$];
  int rd_seen = 0, wr_seen = 0, lat = 1, cyc = 0;
  bit rand_wait = 0, any_req = 0, prev_stall = 0, prev_w = 0;
  logic [31:0] prev_addr;
  logic [15:0] prev_wd;

  sdram_sort_engine dut (
    .clk(clk), .reset_n(reset_n), .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .read_n(read_n), .write_n(write_n), .chipselect(chipselect),
    .address(address), .byteenable(byteenable), .writedata(writedata), .start(start),
    .descending(descending), .src_base(src_base), .dst_base(dst_base), .length(length),
    .busy(busy), .done(done), .error(error), .min_val(min_val), .max_val(max_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input bit ok, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    chk(n, a === e, a, e);
  endtask

  // slave: decides waitrequest/readdatavalid at each negedge for the following posedge
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pd.delete();
      pt.delete();
      waitrequest = 1'b0;
      readdatavalid = 1'b0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_addr", address, prev_addr);
        check("stall_req", prev_w ? write_n : read_n, 0);
        if (prev_w) check("stall_wdata", writedata, prev_wd);
      end
      waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      readdatavalid = pt.size() > 0 && pt[0] == cyc;
      if (readdatavalid) begin
        readdata = pd.pop_front();
        void'(pt.pop_front());
      end
      if (!read_n || !write_n) any_req = 1;
      if (!read_n && !write_n) chk("rw_overlap", 0, 32'h1, 32'h0);
      if (!read_n && !waitrequest) begin
        check("rd_addr", address, src_r + 32'(rd_seen));
        rd_addrs.push_back(address);
        pd.push_back(mem.exists(address) ? mem[address] : 16'h0);
        pt.push_back(cyc + lat);
        rd_seen++;
      end
      if (!write_n && !waitrequest) begin
        check("wr_addr", address, dst_r + 32'(wr_seen));
        check("wr_data", writedata, wr_seen < exp_q.size() ? {16'h0, exp_q[wr_seen]} : 32'hDEAD_BEEF);
        mem[address] = writedata;
        wr_seen++;
      end
      prev_stall = waitrequest && (!read_n || !write_n);
      prev_addr = address;
      prev_wd = writedata;
      prev_w = !write_n;
    end
  end

  task automatic reset_checks();
    check("rst_read_n", read_n, 1);
    check("rst_write_n", write_n, 1);
    check("rst_cs", chipselect, 0);
    check("rst_addr", address, 0);
    check("rst_wdata", writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_min", min_val, 16'hFFFF);
    check("rst_max", max_val, 0);
  endtask

  task automatic launch(input int n, input bit d, input logic [31:0] s, input logic [31:0] t);
    src_r = s;
    dst_r = t;
    rd_seen = 0;
    wr_seen = 0;
    any_req = 0;
    rd_addrs.delete();
    for (int i = 0; i < din.size(); i++) mem[s + 32'(i)] = din[i];
    exp_q = din;
    if (d) exp_q.rsort();
    else exp_q.sort();
    @(posedge clk);
    #1;
    length = 6'(n);
    descending = d;
    src_base = s;
    dst_base = t;
    start = 1'b1;
  endtask

  task automatic finish_run(input int n);
    int c = 0;
    logic [15:0] mn = 16'hFFFF, mx = 16'h0;
    while (!done && c < 600) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("done", done, 1);
    if (!rand_wait) chk("latency", c <= 2 * n + lat + 3, c, 2 * n + lat + 3);
    check("rd_count", rd_seen, n);
    check("wr_count", wr_seen, n);
    check("error", error, 0);
    foreach (din[i]) begin
      if (din[i] < mn) mn = din[i];
      if (din[i] > mx) mx = din[i];
    end
    check("min", min_val, mn);
    check("max", max_val, mx);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic empty_run(input int n, input bit e);
    din.delete();
    launch(n, 0, 32'h7000, 32'h7100);
    @(posedge clk);
    #1;
    check("empty_done", done, 1);
    check("empty_error", error, e);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("empty_idle", done, 0);
    check("empty_err_clr", error, 0);
    check("empty_traffic", any_req, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    check("rst_be", byteenable, 2'b11);
    reset_n = 1'b1;
    // ascending, zero wait
    din = '{16'd7, 16'd3, 16'd9, 16'd3, 16'd1};
    launch(5, 0, 32'h1000, 32'h2000);
    finish_run(5);
    check("t1_d0", mem[32'h2000], 1);
    check("t1_d1", mem[32'h2001], 3);
    check("t1_d2", mem[32'h2002], 3);
    check("t1_d3", mem[32'h2003], 7);
    check("t1_d4", mem[32'h2004], 9);
    check("t1_min", min_val, 1);
    check("t1_max", max_val, 9);
    // descending, random stalls, latency 3
    lat = 3;
    rand_wait = 1;
    din = '{16'h0010, 16'hFFFF, 16'h0000, 16'h8000};
    launch(4, 1, 32'h3000, 32'h4000);
    finish_run(4);
    check("t2_d0", mem[32'h4000], 16'hFFFF);
    check("t2_d1", mem[32'h4001], 16'h8000);
    check("t2_d2", mem[32'h4002], 16'h0010);
    check("t2_d3", mem[32'h4003], 16'h0000);
    // full depth, reversed input
    lat = 2;
    rand_wait = 0;
    din.delete();
    for (int i = 31; i >= 0; i--) din.push_back(16'(i));
    launch(32, 0, 32'h5000, 32'h6000);
    finish_run(32);
    for (int i = 0; i < 32; i++) check("t3_d", mem[32'h6000 + 32'(i)], i);
    // zero length and over-length
    empty_run(0, 0);
    empty_run(40, 1);
    // reset during the second write beat
    lat = 1;
    din = '{16'd5, 16'd2, 16'd8, 16'd1, 16'd9, 16'd4};
    launch(6, 0, 32'h8000, 32'h9000);
    begin
      int c = 0;
      while (wr_seen < 1 && c < 200) begin
        @(posedge clk);
        #1;
        c++;
      end
    end
    chk("reach_beat2", wr_seen >= 1 && !write_n, wr_seen, 1);
    reset_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    reset_checks();
    check("rst_wr_count", wr_seen, 1);
    reset_n = 1'b1;
    din = '{16'd3, 16'd1, 16'd2};
    launch(3, 0, 32'hA000, 32'hB000);
    finish_run(3);
    check("t5_d0", mem[32'hB000], 1);
    check("t5_d1", mem[32'hB001], 2);
    check("t5_d2", mem[32'hB002], 3);
    // source address wrap
    din = '{16'h00AA, 16'h00CC, 16'h00BB};
    launch(3, 1, 32'hFFFF_FFFE, 32'hC000);
    finish_run(3);
    check("wrap_a0", rd_addrs.size() > 0 ? rd_addrs[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFE);
    check("wrap_a1", rd_addrs.size() > 1 ? rd_addrs[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    check("wrap_a2", rd_addrs.size() > 2 ? rd_addrs[2] : 32'hDEAD_BEEF, 32'h0000_0000);
    check("t6_d0", mem[32'hC000], 16'h00CC);
    check("t6_d1", mem[32'hC001], 16'h00BB);
    check("t6_d2", mem[32'hC002], 16'h00AA);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
